// File: rtl/anton_neopixel_apb_mux_pkg.sv
// Shared definitions for the multi-channel neopixel APB front-end.
//   MUX_CHANNELS_DEFAULT / MUX_TIMEOUT_DEFAULT : default parameter values
//   mux_state_e : FSM state encoding (2-bit)
//   ch_bits()   : channel-index width, never less than one bit
package anton_neopixel_apb_mux_pkg;

  localparam int unsigned MUX_CHANNELS_DEFAULT = 4;
  localparam int unsigned MUX_TIMEOUT_DEFAULT  = 64;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStrobe = 2'd1,
    StWait   = 2'd2,
    StResp   = 2'd3
  } mux_state_e;

  function automatic int unsigned ch_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/anton_apb_timeout_counter.sv
// Wait-state watchdog counter for the APB mux.
// Ports:
//   clk      : clock
//   rst_n    : synchronous active-low reset
//   clear    : force the count to zero
//   enable   : advance the count by one (saturates at the terminal value)
//   terminal : count has reached TIMEOUT-1
module anton_apb_timeout_counter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] count_q;

  assign terminal = (count_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !terminal) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/anton_neopixel_apb_mux.sv
// APB3 slave that fans one APB port out to CHANNELS neopixel bus ports.
// Every transfer goes IDLE -> STROBE -> WAIT -> RESP; an out-of-range channel
// index skips straight to RESP with an error, and a stalled channel is errored
// after TIMEOUT wait cycles. All outputs are registered.
// Ports:
//   apbPclk, apbPresern : clock, synchronous active-low reset
//   apbPselx, apbPenable, apbPwrite, apbPaddr, apbPwData : APB request
//   apbPrData, apbPready, apbPslverr : APB response
//   chAddr, chDataOut   : shared channel address / write data
//   chWrite, chRead     : one-hot per-channel strobes
//   chDataIn, chReady   : per-channel read data (flattened) and completion
module anton_neopixel_apb_mux
  import anton_neopixel_apb_mux_pkg::*;
#(
  parameter int unsigned CHANNELS   = MUX_CHANNELS_DEFAULT,
  parameter int unsigned BUS_ADDR_W = 18,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TIMEOUT    = MUX_TIMEOUT_DEFAULT,
  localparam int unsigned CH_BITS   = ch_bits(CHANNELS),
  localparam int unsigned ADDR_W    = BUS_ADDR_W + CH_BITS + 2
) (
  input  logic                         apbPclk,
  input  logic                         apbPresern,
  input  logic                         apbPselx,
  input  logic                         apbPenable,
  input  logic                         apbPwrite,
  input  logic [ADDR_W-1:0]            apbPaddr,
  input  logic [DATA_W-1:0]            apbPwData,
  output logic [DATA_W-1:0]            apbPrData,
  output logic                         apbPready,
  output logic                         apbPslverr,
  output logic [BUS_ADDR_W-1:0]        chAddr,
  output logic [DATA_W-1:0]            chDataOut,
  output logic [CHANNELS-1:0]          chWrite,
  output logic [CHANNELS-1:0]          chRead,
  input  logic [CHANNELS*DATA_W-1:0]   chDataIn,
  input  logic [CHANNELS-1:0]          chReady
);

  // One extra bit so CHANNELS itself is representable (e.g. 16 with 4 index bits).
  localparam logic [CH_BITS:0] CH_LIMIT = (CH_BITS + 1)'(CHANNELS);

  mux_state_e state_q, state_d;

  logic [CH_BITS-1:0]    ch_q, ch_d;
  logic                  write_q, write_d;
  logic [BUS_ADDR_W-1:0] ch_addr_q, ch_addr_d;
  logic [DATA_W-1:0]     ch_data_q, ch_data_d;
  logic [CHANNELS-1:0]   ch_write_q, ch_write_d;
  logic [CHANNELS-1:0]   ch_read_q, ch_read_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_W-1:0]     prdata_q, prdata_d;

  logic                  cnt_clear, cnt_en, cnt_terminal;

  logic [CH_BITS-1:0]    setup_idx;
  logic [BUS_ADDR_W-1:0] setup_addr;
  logic                  setup_phase;
  logic                  setup_valid;
  logic [CHANNELS-1:0]   setup_onehot;
  logic [DATA_W-1:0]     sel_data;
  logic                  sel_ready;
  logic                  unused_paddr;

  assign setup_idx    = apbPaddr[ADDR_W-1:BUS_ADDR_W+2];
  assign setup_addr   = apbPaddr[BUS_ADDR_W+1:2];
  assign setup_phase  = apbPselx && !apbPenable;
  assign setup_valid  = ({1'b0, setup_idx} < CH_LIMIT);
  assign setup_onehot = CHANNELS'(1) << setup_idx;
  assign unused_paddr = ^apbPaddr[1:0];

  // Only the latched channel's data/ready matter; the others are ignored.
  assign sel_data  = chDataIn[ch_q*DATA_W +: DATA_W];
  assign sel_ready = chReady[ch_q];

  anton_apb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (apbPclk),
    .rst_n    (apbPresern),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (cnt_terminal)
  );

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    write_d    = write_q;
    ch_addr_d  = ch_addr_q;
    ch_data_d  = ch_data_q;
    ch_write_d = '0;
    ch_read_d  = '0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (setup_phase) begin
          ch_d    = setup_idx;
          write_d = apbPwrite;
          if (!setup_valid) begin
            // Bad channel: answer immediately, nothing reaches the channels.
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d   = StStrobe;
            ch_addr_d = setup_addr;
            ch_data_d = apbPwData;
            if (apbPwrite) begin
              ch_write_d = setup_onehot;
            end else begin
              ch_read_d = setup_onehot;
            end
          end
        end
      end

      StStrobe: begin
        cnt_clear = 1'b1;
        state_d   = apbPselx ? StWait : StIdle;
      end

      StWait: begin
        if (!apbPselx) begin
          state_d = StIdle;
        end else if (sel_ready) begin
          state_d  = StResp;
          pready_d = 1'b1;
          prdata_d = write_q ? '0 : sel_data;
        end else if (cnt_terminal) begin
          state_d   = StResp;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge apbPclk) begin
    if (!apbPresern) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      write_q    <= 1'b0;
      ch_addr_q  <= '0;
      ch_data_q  <= '0;
      ch_write_q <= '0;
      ch_read_q  <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      write_q    <= write_d;
      ch_addr_q  <= ch_addr_d;
      ch_data_q  <= ch_data_d;
      ch_write_q <= ch_write_d;
      ch_read_q  <= ch_read_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
    end
  end

  assign chAddr     = ch_addr_q;
  assign chDataOut  = ch_data_q;
  assign chWrite    = ch_write_q;
  assign chRead     = ch_read_q;
  assign apbPready  = pready_q;
  assign apbPslverr = pslverr_q;
  assign apbPrData  = prdata_q;

endmodule
